// File: rtl/i2s_codec_pkg.sv
// Shared constants and the stereo sample type for the on-chip I2S codec stand-in.
package i2s_codec_pkg;

    localparam int DATA_W   = 24;
    localparam int SLOT_W   = 32;
    localparam int BCLK_DIV = 2;

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK/LRCK timebase: clk divider, frame bit position counter and tick strobes.
module i2s_bclk_gen
    import i2s_codec_pkg::*;
#(
    parameter int SLOT_W   = i2s_codec_pkg::SLOT_W,
    parameter int BCLK_DIV = i2s_codec_pkg::BCLK_DIV,
    parameter int POS_W    = $clog2(2 * SLOT_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             bclk,
    output logic             lrck,
    output logic             fall_tick,
    output logic             rise_tick,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] next_pos
);

    localparam int               DIV_W    = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * SLOT_W - 1);
    localparam logic [POS_W-1:0] SLOT_P   = POS_W'(SLOT_W);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap      = (div_cnt == DIV_LAST);
    // Strobes are high in the cycle whose closing edge moves bclk.
    assign fall_tick = wrap & bclk;
    assign rise_tick = wrap & ~bclk;
    assign next_pos  = (pos == POS_LAST) ? '0 : pos + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Reset parks pos on the last right-slot bit so the first fall tick is a frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos  <= POS_LAST;
            lrck <= 1'b1;
        end else if (fall_tick) begin
            pos  <= next_pos;
            lrck <= (next_pos >= SLOT_P);
        end
    end

endmodule

// File: rtl/i2s_codec_master.sv
// Codec-side I2S master: generates BCLK/LRCK, serializes TX pairs onto adcdat
// and deserializes dacdat into RX pairs.
module i2s_codec_master
    import i2s_codec_pkg::*;
#(
    parameter int DATA_W   = i2s_codec_pkg::DATA_W,
    parameter int SLOT_W   = i2s_codec_pkg::SLOT_W,
    parameter int BCLK_DIV = i2s_codec_pkg::BCLK_DIV
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_left_data,
    input  logic [DATA_W-1:0] tx_right_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_left_data,
    output logic [DATA_W-1:0] rx_right_data,
    output logic              rx_valid,
    output logic              bclk,
    output logic              lrck,
    output logic              adcdat,
    input  logic              dacdat,
    output logic              tx_underrun
);

    localparam int               POS_W  = $clog2(2 * SLOT_W);
    localparam logic [POS_W-1:0] SLOT_P = POS_W'(SLOT_W);
    localparam logic [POS_W-1:0] DATA_P = POS_W'(DATA_W);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } pair_t;

    logic             fall_tick;
    logic             rise_tick;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] next_pos;

    i2s_bclk_gen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV),
        .POS_W    (POS_W)
    ) u_bclk_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .bclk      (bclk),
        .lrck      (lrck),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick),
        .pos       (pos),
        .next_pos  (next_pos)
    );

    // TX acts on the slot being entered at a fall tick; RX on the slot held during a rise tick.
    logic             next_right;
    logic [POS_W-1:0] next_s;
    logic             tx_bit_slot;
    logic             cur_right;
    logic [POS_W-1:0] cur_s;
    logic             rx_bit_slot;
    logic             frame_start;

    assign next_right  = (next_pos >= SLOT_P);
    assign next_s      = next_right ? (next_pos - SLOT_P) : next_pos;
    assign tx_bit_slot = (next_s != '0) && (next_s <= DATA_P);
    assign cur_right   = (pos >= SLOT_P);
    assign cur_s       = cur_right ? (pos - SLOT_P) : pos;
    assign rx_bit_slot = (cur_s != '0) && (cur_s <= DATA_P);
    assign frame_start = fall_tick && (next_pos == '0);

    pair_t hold;
    logic  hold_full;
    logic  transfer;

    assign transfer = tx_valid && !hold_full;
    assign tx_ready = !hold_full;

    // A same-cycle transfer wins over the frame-start clear, so the new pair stays held.
    // NOTE: the holding register is small and its contents are observable, so it is reset like any other flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (frame_start) begin
                hold      <= '0;
                hold_full <= 1'b0;
            end
            if (transfer) begin
                hold.left  <= tx_left_data;
                hold.right <= tx_right_data;
                hold_full  <= 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] tx_sr_l;
    logic [DATA_W-1:0] tx_sr_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_sr_l     <= '0;
            tx_sr_r     <= '0;
            adcdat      <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (fall_tick) begin
                adcdat <= 1'b0;
                if (frame_start) begin
                    tx_sr_l     <= hold_full ? hold.left  : '0;
                    tx_sr_r     <= hold_full ? hold.right : '0;
                    tx_underrun <= !hold_full;
                end else if (tx_bit_slot) begin
                    if (next_right) begin
                        adcdat  <= tx_sr_r[DATA_W-1];
                        tx_sr_r <= {tx_sr_r[DATA_W-2:0], 1'b0};
                    end else begin
                        adcdat  <= tx_sr_l[DATA_W-1];
                        tx_sr_l <= {tx_sr_l[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    logic [DATA_W-1:0] rx_sr_l;
    logic [DATA_W-1:0] rx_sr_r;

    // The last right-slot bit goes straight into rx_right_data alongside its shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sr_l       <= '0;
            rx_sr_r       <= '0;
            rx_left_data  <= '0;
            rx_right_data <= '0;
            rx_valid      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rise_tick && rx_bit_slot) begin
                if (cur_right) begin
                    rx_sr_r <= {rx_sr_r[DATA_W-2:0], dacdat};
                    if (cur_s == DATA_P) begin
                        rx_left_data  <= rx_sr_l;
                        rx_right_data <= {rx_sr_r[DATA_W-2:0], dacdat};
                        rx_valid      <= 1'b1;
                    end
                end else begin
                    rx_sr_l <= {rx_sr_l[DATA_W-2:0], dacdat};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_codec_master.sv
// Self-checking bench: per-cycle reference model derived from edge counts since reset.
module tb_i2s_codec_master;
    import i2s_codec_pkg::*;

    localparam int DW    = DATA_W;
    localparam int SW    = SLOT_W;
    localparam int BD    = BCLK_DIV;
    localparam int FRAME = 2 * SW * 2 * BD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] tx_left_data = '0;
    logic [DW-1:0] tx_right_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_left_data;
    logic [DW-1:0] rx_right_data;
    logic          rx_valid;
    logic          bclk;
    logic          lrck;
    logic          adcdat;
    logic          dacdat;
    logic          tx_underrun;
    logic          loopback = 1'b0;
    logic          dac_rand = 1'b0;

    always #5 clk = ~clk;
    assign dacdat = loopback ? adcdat : dac_rand;

    i2s_codec_master #(
        .DATA_W   (DW),
        .SLOT_W   (SW),
        .BCLK_DIV (BD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tx_left_data  (tx_left_data),
        .tx_right_data (tx_right_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_left_data  (rx_left_data),
        .rx_right_data (rx_right_data),
        .rx_valid      (rx_valid),
        .bclk          (bclk),
        .lrck          (lrck),
        .adcdat        (adcdat),
        .dacdat        (dacdat),
        .tx_underrun   (tx_underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: everything follows from k, the clk edges since reset release.
    int            k;
    int            m_pos;
    bit            m_hold_full;
    stereo_t       m_hold;
    stereo_t       m_word;
    stereo_t       e_rx;
    logic [DW-1:0] acc_l;
    logic [DW-1:0] acc_r;
    logic          e_bclk, e_lrck, e_adc, e_under, e_rxv;

    task automatic model_reset();
        k = 0;
        m_pos = 2 * SW - 1;
        m_hold_full = 1'b0;
        m_hold = '0;
        m_word = '0;
        e_rx = '0;
        acc_l = '0;
        acc_r = '0;
        e_bclk = 1'b0;
        e_lrck = 1'b1;
        e_adc = 1'b0;
        e_under = 1'b0;
        e_rxv = 1'b0;
    endtask

    task automatic model_step();
        int f, s;
        bit ch, fs, rs, xfer;
        logic dbit;
        dbit = loopback ? e_adc : dac_rand;
        xfer = tx_valid && !m_hold_full;
        k++;
        f = k / (2 * BD);
        m_pos = (2 * SW - 1 + f) % (2 * SW);
        fs = ((k % (2 * BD)) == 0) && (m_pos == 0);
        rs = ((k % (2 * BD)) == BD);
        s = m_pos % SW;
        ch = (m_pos >= SW);
        e_under = fs && !m_hold_full;
        if (fs) begin
            m_word = m_hold_full ? m_hold : '0;
            m_hold_full = 1'b0;
        end
        if (xfer) begin
            m_hold.left = tx_left_data;
            m_hold.right = tx_right_data;
            m_hold_full = 1'b1;
        end
        e_rxv = 1'b0;
        if (rs && s >= 1 && s <= DW) begin
            if (ch) acc_r[DW-s] = dbit;
            else    acc_l[DW-s] = dbit;
            if (ch && s == DW) begin
                e_rx.left = acc_l;
                e_rx.right = acc_r;
                e_rxv = 1'b1;
            end
        end
        e_bclk = ((k / BD) % 2) == 1;
        e_lrck = ch;
        if (s >= 1 && s <= DW) e_adc = ch ? m_word.right[DW-s] : m_word.left[DW-s];
        else                   e_adc = 1'b0;
    endtask

    task automatic check_outputs();
        check("bclk", 32'(bclk), 32'(e_bclk));
        check("lrck", 32'(lrck), 32'(e_lrck));
        check("adcdat", 32'(adcdat), 32'(e_adc));
        check("tx_ready", 32'(tx_ready), 32'(!m_hold_full));
        check("tx_underrun", 32'(tx_underrun), 32'(e_under));
        check("rx_valid", 32'(rx_valid), 32'(e_rxv));
        check("rx_left", 32'(rx_left_data), 32'(e_rx.left));
        check("rx_right", 32'(rx_right_data), 32'(e_rx.right));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        else         model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        dac_rand = 1'($urandom);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bit accepted;
        int guard = 0;
        tx_left_data = l;
        tx_right_data = r;
        tx_valid = 1'b1;
        do begin
            accepted = !m_hold_full;
            cycle();
            guard++;
        end while (!accepted && guard < 2 * FRAME);
        if (!accepted) check("send_timeout", 32'd1, 32'd0);
        tx_valid = 1'b0;
    endtask

    // Leaves the bench so that the next clk edge is a frame start.
    task automatic wait_frame_edge();
        int guard = 0;
        while (!(((k + 1) % (2 * BD)) == 0 && m_pos == 2 * SW - 1)) begin
            cycle();
            guard++;
            if (guard > 2 * FRAME) begin
                check("frame_wait_timeout", 32'd1, 32'd0);
                return;
            end
        end
    endtask

    task automatic capture_frame(output logic [2*SW-1:0] bits);
        bits = '0;
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            if ((k % (2 * BD)) == 0) bits = {bits[2*SW-2:0], adcdat};
        end
    endtask

    function automatic logic [2*SW-1:0] frame_bits(input logic [DW-1:0] l, input logic [DW-1:0] r);
        logic [SW-1:0] sl, sr;
        sl = '0;
        sr = '0;
        sl[SW-2 -: DW] = l;
        sr[SW-2 -: DW] = r;
        return {sl, sr};
    endfunction

    logic [2*SW-1:0] bits;
    logic [2*SW-1:0] want;
    int              cnt;
    int              guard;
    logic [DW-1:0]   pat;
    bit              rdy;

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #1 check_outputs();
        run(3);
        reset_n = 1'b1;

        // Single pair: exact bit pattern of one frame.
        send_pair(24'h800001, 24'h7FFFFE);
        wait_frame_edge();
        capture_frame(bits);
        check("single_left_slot", bits[2*SW-1:SW], 32'h4000_0080);
        check("single_right_slot", bits[SW-1:0], 32'h3FFF_FF00);

        // Loopback: the received pair equals the transmitted pair of the same frame.
        loopback = 1'b1;
        send_pair(24'h123456, 24'hABCDEF);
        wait_frame_edge();
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (!rx_valid && guard < 2 * FRAME);
        check("loop_rx_valid", 32'(rx_valid), 32'd1);
        check("loop_left", 32'(rx_left_data), 32'h123456);
        check("loop_right", 32'(rx_right_data), 32'hABCDEF);
        run(FRAME);

        // Underrun: no pairs for three frames.
        loopback = 1'b0;
        wait_frame_edge();
        cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cycle();
            if (tx_underrun) cnt++;
        end
        check("underrun_count", 32'(cnt), 32'd3);

        // Backpressure: tx_valid held high with an incrementing pattern.
        wait_frame_edge();
        pat = '0;
        tx_left_data = pat;
        tx_right_data = ~pat;
        tx_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            rdy = tx_ready;
            cycle();
            if (rdy) begin
                cnt++;
                pat = pat + 1'b1;
                tx_left_data = pat;
                tx_right_data = ~pat;
            end
        end
        tx_valid = 1'b0;
        check("bp_accepts", 32'(cnt), 32'd4);

        // Collision: transfer in the frame-start cycle while the holding register is empty.
        wait_frame_edge();
        cycle();
        wait_frame_edge();
        tx_left_data = 24'h5A5A5A;
        tx_right_data = 24'hC3C3C3;
        tx_valid = 1'b1;
        cycle();
        tx_valid = 1'b0;
        check("col_ready", 32'(tx_ready), 32'd0);
        check("col_underrun", 32'(tx_underrun), 32'd1);
        wait_frame_edge();
        capture_frame(bits);
        want = frame_bits(24'h5A5A5A, 24'hC3C3C3);
        check("col_left_slot", bits[2*SW-1:SW], want[2*SW-1:SW]);
        check("col_right_slot", bits[SW-1:0], want[SW-1:0]);

        // Random traffic against the model.
        loopback = 1'($urandom);
        for (int i = 0; i < 8 * FRAME; i++) begin
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_left_data = DW'($urandom);
            tx_right_data = DW'($urandom);
            cycle();
        end
        tx_valid = 1'b0;
        loopback = 1'b0;

        // Mid-frame reset at pos 40, then restart latency.
        guard = 0;
        while (m_pos != 40 && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
        check("reset_pos_reached", 32'(m_pos), 32'd40);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        run(3);
        reset_n = 1'b1;
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (!tx_underrun && cnt < 4 * BD);
        check("restart_latency", 32'(cnt), 32'(2 * BD));
        run(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
